// File: rtl/bp_fe_fetch_buffer_pkg.sv
// Front-end shared definitions: processor configurations, width helpers and
// the fetch buffer entry struct macro.

`ifndef BP_FE_FETCH_BUFFER_PKG_SV
`define BP_FE_FETCH_BUFFER_PKG_SV

// Entry stored per fetched instruction. instr_width_p is taken from the
// enclosing scope so every user agrees with its own config.
`define BP_FE_FETCH_BUFFER_ENTRY_S(vaddr_width_mp, branch_metadata_fwd_width_mp) \
  typedef struct packed {                                                          \
    logic [vaddr_width_mp-1:0]               pc;                                   \
    logic [instr_width_p-1:0]                instr;                                \
    logic [branch_metadata_fwd_width_mp-1:0] br_metadata;                          \
  } bp_fe_fetch_buffer_entry_s

package bp_fe_pkg;

  typedef enum logic [1:0] {
    e_bp_default_cfg = 2'd0,
    e_bp_small_cfg   = 2'd1
  } bp_params_e;

  function automatic int bp_vaddr_width(bp_params_e cfg);
    case (cfg)
      e_bp_default_cfg: return 39;
      e_bp_small_cfg:   return 32;
      default:          return 39;
    endcase
  endfunction

  function automatic int bp_instr_width(bp_params_e cfg);
    case (cfg)
      e_bp_default_cfg: return 32;
      e_bp_small_cfg:   return 32;
      default:          return 32;
    endcase
  endfunction

  function automatic int bp_branch_metadata_fwd_width(bp_params_e cfg);
    case (cfg)
      e_bp_default_cfg: return 35;
      e_bp_small_cfg:   return 16;
      default:          return 35;
    endcase
  endfunction

endpackage

`endif

// File: rtl/bp_fe_fetch_buffer_mem.sv
// Simple 1-write / 1-read register-file storage with asynchronous read.
// Contents are not reset; validity is tracked by the owner's pointers.

module bsg_mem_1r1w #(
  parameter int width_p = 8,
  parameter int els_p   = 4,
  localparam int addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1
) (
  input  logic                     w_clk_i,
  input  logic                     w_v_i,
  input  logic [addr_width_lp-1:0] w_addr_i,
  input  logic [width_p-1:0]       w_data_i,
  input  logic [addr_width_lp-1:0] r_addr_i,
  output logic [width_p-1:0]       r_data_o
);

  logic [width_p-1:0] mem_q [els_p];

  // Capture write data into the addressed entry.
  always_ff @(posedge w_clk_i) begin
    if (w_v_i) begin
      mem_q[w_addr_i] <= w_data_i;
    end
  end

  assign r_data_o = mem_q[r_addr_i];

endmodule

// File: rtl/bp_fe_fetch_buffer.sv
// Fetch buffer between PC generation and the FE queue. A circular FIFO with
// wrap-bit pointers; packets arriving while full are bounced back as replays.

module bp_fe_fetch_buffer
  import bp_fe_pkg::*;
#(
  parameter bp_params_e bp_params_p = e_bp_default_cfg,
  parameter int els_p = 4,
  localparam int vaddr_width_p = bp_vaddr_width(bp_params_p),
  localparam int instr_width_p = bp_instr_width(bp_params_p),
  localparam int branch_metadata_fwd_width_p = bp_branch_metadata_fwd_width(bp_params_p),
  localparam int count_width_lp = $clog2(els_p+1)
) (
  input  logic                                   clk_i,
  input  logic                                   reset_i,

  input  logic [vaddr_width_p-1:0]               fetch_pc_i,
  input  logic [instr_width_p-1:0]               fetch_instr_i,
  input  logic [branch_metadata_fwd_width_p-1:0] fetch_br_metadata_i,
  input  logic                                   fetch_v_i,
  output logic                                   replay_v_o,

  input  logic                                   flush_i,

  output logic [vaddr_width_p-1:0]               fe_queue_pc_o,
  output logic [instr_width_p-1:0]               fe_queue_instr_o,
  output logic [branch_metadata_fwd_width_p-1:0] fe_queue_br_metadata_o,
  output logic                                   fe_queue_v_o,
  input  logic                                   fe_queue_ready_i,

  output logic [count_width_lp-1:0]              count_o
);

  localparam int ptr_width_lp = $clog2(els_p);

  `BP_FE_FETCH_BUFFER_ENTRY_S(vaddr_width_p, branch_metadata_fwd_width_p);

  localparam int entry_width_lp = $bits(bp_fe_fetch_buffer_entry_s);

  // MSB of each pointer is the wrap bit, low bits index storage.
  logic [ptr_width_lp:0]   wptr_q, wptr_d;
  logic [ptr_width_lp:0]   rptr_q, rptr_d;
  logic [count_width_lp-1:0] count_q, count_d;

  logic full_s, empty_s, enq_s, deq_s;
  bp_fe_fetch_buffer_entry_s w_entry_s, r_entry_s;

  // Occupancy is judged purely from registered pointers, so a same-cycle
  // dequeue never frees a slot for the incoming packet.
  assign full_s  = (wptr_q[ptr_width_lp-1:0] == rptr_q[ptr_width_lp-1:0])
                 & (wptr_q[ptr_width_lp] != rptr_q[ptr_width_lp]);
  assign empty_s = (wptr_q == rptr_q);

  assign enq_s = fetch_v_i & ~full_s & ~flush_i & ~reset_i;
  assign deq_s = ~empty_s & fe_queue_ready_i & ~flush_i & ~reset_i;

  assign replay_v_o   = fetch_v_i & full_s & ~flush_i & ~reset_i;
  assign fe_queue_v_o = ~empty_s;
  assign count_o      = count_q;

  // Next-state pointers and occupancy from the enqueue/dequeue decisions.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (enq_s) begin
      wptr_d = wptr_q + {{ptr_width_lp{1'b0}}, 1'b1};
    end else begin
      wptr_d = wptr_q;
    end
    if (deq_s) begin
      rptr_d = rptr_q + {{ptr_width_lp{1'b0}}, 1'b1};
    end else begin
      rptr_d = rptr_q;
    end
    case ({enq_s, deq_s})
      2'b10:   count_d = count_q + {{(count_width_lp-1){1'b0}}, 1'b1};
      2'b01:   count_d = count_q - {{(count_width_lp-1){1'b0}}, 1'b1};
      default: count_d = count_q;
    endcase
  end

  // Pointer/count state; reset and flush both empty the buffer.
  always_ff @(posedge clk_i) begin
    if (reset_i | flush_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  assign w_entry_s.pc          = fetch_pc_i;
  assign w_entry_s.instr       = fetch_instr_i;
  assign w_entry_s.br_metadata = fetch_br_metadata_i;

  bsg_mem_1r1w #(
    .width_p (entry_width_lp),
    .els_p   (els_p)
  ) mem (
    .w_clk_i  (clk_i),
    .w_v_i    (enq_s),
    .w_addr_i (wptr_q[ptr_width_lp-1:0]),
    .w_data_i (w_entry_s),
    .r_addr_i (rptr_q[ptr_width_lp-1:0]),
    .r_data_o (r_entry_s)
  );

  assign fe_queue_pc_o          = r_entry_s.pc;
  assign fe_queue_instr_o       = r_entry_s.instr;
  assign fe_queue_br_metadata_o = r_entry_s.br_metadata;

endmodule

// File: doc/bp_fe_fetch_buffer.md
BP_FE_FETCH_BUFFER -- requirements
Module: bp_fe_fetch_buffer

Interface
REQ-001 Parameter: bp_params_p, default e_bp_default_cfg, processor config supplying vaddr_width_p, instr_width_p, branch_metadata_fwd_width_p.
REQ-002 Parameter: els_p, default 4, entry count; power of two, >= 2.
REQ-003 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-004 reset_i  input  1  synchronous, active-high reset.
REQ-005 fetch_pc_i  input  vaddr_width_p  PC of the fetched instruction.
REQ-006 fetch_instr_i  input  instr_width_p  fetched instruction.
REQ-007 fetch_br_metadata_i  input  branch_metadata_fwd_width_p  prediction metadata for the fetch.
REQ-008 fetch_v_i  input  1  fetch packet valid; valid-only, no backpressure handshake.
REQ-009 replay_v_o  output  1  fetch packet rejected; PC generation must refetch it.
REQ-010 flush_i  input  1  backend redirect; discard all buffered and incoming packets.
REQ-011 fe_queue_pc_o  output  vaddr_width_p  head entry PC.
REQ-012 fe_queue_instr_o  output  instr_width_p  head entry instruction.
REQ-013 fe_queue_br_metadata_o  output  branch_metadata_fwd_width_p  head entry metadata.
REQ-014 fe_queue_v_o  output  1  head entry valid.
REQ-015 fe_queue_ready_i  input  1  consumer ready; ready-valid, transfer on v_o & ready_i.
REQ-016 count_o  output  $clog2(els_p+1)  current occupancy.

Function
REQ-017 Storage SHALL be a circular FIFO of els_p entries, with read/write pointers of $clog2(els_p) bits plus a wrap bit each.
REQ-018 Full SHALL be equal pointer index with differing wrap bits; empty SHALL be equal index with equal wrap bits.
REQ-019 Enqueue SHALL occur when fetch_v_i & ~full & ~flush_i.
REQ-020 replay_v_o SHALL equal fetch_v_i & full & ~flush_i, combinationally in the same cycle.
REQ-021 A dequeue in the same cycle as full SHALL NOT admit the incoming packet; full is evaluated on registered state only.
REQ-022 Dequeue SHALL occur when fe_queue_v_o & fe_queue_ready_i & ~flush_i.
REQ-023 fe_queue_v_o SHALL equal ~empty; no bypass, so an enqueued packet is visible one cycle after enqueue.
REQ-024 Head outputs SHALL reflect the entry at the read pointer; their value is don't-care when fe_queue_v_o=0.
REQ-025 Simultaneous enqueue and dequeue when neither full nor empty SHALL both take effect, leaving count_o unchanged.
REQ-026 Pointers SHALL wrap modulo els_p; the wrap bit toggles on index rollover.
REQ-027 flush_i SHALL have top priority: next cycle pointers are equal and count_o=0, with no enqueue, dequeue, or replay in that cycle.
REQ-028 count_o SHALL be registered and SHALL be incremented on enqueue-only, decremented on dequeue-only, and held otherwise.
REQ-029 fe_queue_ready_i asserted while empty SHALL have no effect.

Reset
REQ-030 On reset_i: pointers=0, count_o=0, fe_queue_v_o=0, replay_v_o=0 (gated by reset_i).
REQ-031 Reset mid-operation SHALL discard all entries and suppress any enqueue/dequeue that cycle.
REQ-032 Storage contents SHALL NOT require reset.

Structure
REQ-033 The entry struct (pc, instr, br_metadata) SHALL be declared by a macro bp_fe_fetch_buffer_entry_s in bp_fe_pkg, parameterized by vaddr_width_p and branch_metadata_fwd_width_p.
REQ-034 Storage SHALL use one sub-module, bsg_mem_1r1w (els_p x entry width, async read); pointer/count logic stays in this module.

Verification (els_p=4)
REQ-035 Fill: 4 fetches (pc 0x80000000..0x8000000C) with ready=0 -> count_o=4, replay_v_o=0; 5th fetch -> replay_v_o=1 and count stays 4.
REQ-036 Drain: after REQ-035 fill, ready=1 -> heads 0x80000000,04,08,0C on consecutive cycles, then fe_queue_v_o=0 and count_o=0.
REQ-037 Wrap: 10 back-to-back fetches with ready=1 -> in-order output, count_o oscillates 0..1, pointers wrap twice, no replay.
REQ-038 Flush: count_o=3 plus fetch_v_i=1 and flush_i=1 in one cycle -> next cycle count_o=0, fe_queue_v_o=0, replay_v_o=0 in the flush cycle.
REQ-039 Full+dequeue: count_o=4, ready=1, fetch_v_i=1 -> replay_v_o=1, dequeue occurs, count_o=3 next cycle.
REQ-040 Reset: reset_i pulsed with count_o=2 -> count_o=0, fe_queue_v_o=0 next cycle; subsequent fetch 0x1000 emerges one cycle later.
